// File: rtl/semaphore_arbiter_pkg.sv
// Shared types and helpers for the hardware semaphore table.
// Op/state encodings and width helpers used by the arbiter and its top.
package semaphore_arbiter_pkg;

   localparam logic OP_RELEASE = 1'b0;
   localparam logic OP_ACQUIRE = 1'b1;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Index widths never collapse to zero bits.
   function automatic int id_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/semaphore_rr_arbiter.sv
// Combinational round-robin grant over the pending request vector.
// Search starts at ptr_i and wraps modulo the number of cores.
module semaphore_rr_arbiter
   import semaphore_arbiter_pkg::*;
#(
   parameter int NumberOfCores = 2,
   localparam int CoreIdW = id_width(NumberOfCores)
) (
   input  logic [NumberOfCores-1:0] req_i,
   input  logic [CoreIdW-1:0]       ptr_i,
   output logic [NumberOfCores-1:0] gnt_o,
   output logic [CoreIdW-1:0]       idx_o,
   output logic                     valid_o
);

   always_comb begin
      logic             found;
      logic [CoreIdW-1:0] cand;
      found = 1'b0;
      cand  = '0;
      gnt_o = '0;
      idx_o = '0;
      for (int i = 0; i < NumberOfCores; i++) begin
         cand = CoreIdW'((int'(ptr_i) + i) % NumberOfCores);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/semaphore_arbiter.sv
// Semaphore table owner: captures per-core acquire/release requests,
// serialises them round-robin and maintains lock bits and owners.
module semaphore_arbiter
   import semaphore_arbiter_pkg::*;
#(
   parameter int NumberOfSemaphores = 4,
   parameter int NumberOfCores = 2,
   localparam int SemIdW = id_width(NumberOfSemaphores),
   localparam int CoreIdW = id_width(NumberOfCores)
) (
   input  logic                                      SEMAPHOREARBITER_Clk,
   input  logic                                      SEMAPHOREARBITER_Reset,
   input  logic [NumberOfCores-1:0]                  SEMAPHOREARBITER_Req,
   input  logic [NumberOfCores-1:0]                  SEMAPHOREARBITER_Op,
   input  logic [NumberOfCores*SemIdW-1:0]           SEMAPHOREARBITER_SemId,
   output logic [NumberOfCores-1:0]                  SEMAPHOREARBITER_Ack,
   output logic [NumberOfCores-1:0]                  SEMAPHOREARBITER_Result,
   output logic [NumberOfCores-1:0]                  SEMAPHOREARBITER_Busy,
   output logic [NumberOfSemaphores-1:0]             SEMAPHOREARBITER_Locked,
   output logic [NumberOfSemaphores*NumberOfCores-1:0] SEMAPHOREARBITER_WE_buffer
);

   localparam int NC = NumberOfCores;
   localparam int NS = NumberOfSemaphores;

   state_t             state_q, state_d;
   logic [NC-1:0]      busy_q, busy_d;
   logic [NC-1:0]      op_q, op_d;
   logic [SemIdW-1:0]  id_q [NC];
   logic [SemIdW-1:0]  id_d [NC];
   logic [NC-1:0]      ack_q, ack_d;
   logic [NC-1:0]      res_q, res_d;
   logic [NC-1:0]      win_oh_q, win_oh_d;
   logic [CoreIdW-1:0] win_q, win_d;
   logic [CoreIdW-1:0] ptr_q, ptr_d;
   logic [NS-1:0]      lock_q, lock_d;
   logic [CoreIdW-1:0] owner_q [NS];
   logic [CoreIdW-1:0] owner_d [NS];
   logic [NS*NC-1:0]   we_q, we_d;

   logic [NC-1:0]      gnt;
   logic [CoreIdW-1:0] gnt_idx;
   logic               gnt_any;
   logic [NC-1:0]      clr;
   logic [NC-1:0]      cap;
   logic [SemIdW-1:0]  sel_id;
   logic               sel_op;
   logic               in_range;
   logic               hit;
   logic               ok;

   semaphore_rr_arbiter #(
      .NumberOfCores(NC)
   ) u_rr (
      .req_i  (busy_q),
      .ptr_i  (ptr_q),
      .gnt_o  (gnt),
      .idx_o  (gnt_idx),
      .valid_o(gnt_any)
   );

   assign sel_id   = id_q[win_q];
   assign sel_op   = op_q[win_q];
   assign in_range = int'(sel_id) < NS;

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      win_oh_d = win_oh_q;
      ptr_d    = ptr_q;
      ack_d    = '0;
      res_d    = res_q;
      lock_d   = lock_q;
      owner_d  = owner_q;
      clr      = '0;
      hit      = 1'b0;
      ok       = 1'b0;
      unique case (state_q)
         ARB: begin
            if (gnt_any) begin
               win_d    = gnt_idx;
               win_oh_d = gnt;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            if (in_range) begin
               hit = lock_q[sel_id] && (owner_q[sel_id] == win_q);
               if (sel_op == OP_ACQUIRE) begin
                  if (!lock_q[sel_id]) begin
                     lock_d[sel_id]  = 1'b1;
                     owner_d[sel_id] = win_q;
                     ok              = 1'b1;
                  end else begin
                     ok = hit;
                  end
               end else if (hit) begin
                  lock_d[sel_id] = 1'b0;
                  ok             = 1'b1;
               end
            end
            res_d[win_q] = ok;
            ack_d        = win_oh_q;
            state_d      = DONE;
         end
         DONE: begin
            clr     = win_oh_q;
            ptr_d   = (win_q == CoreIdW'(NC - 1)) ? '0 : win_q + 1'b1;
            state_d = ARB;
         end
         default: state_d = ARB;
      endcase

      // The finishing core may queue its next request in its Ack cycle.
      cap    = SEMAPHOREARBITER_Req & (~busy_q | clr);
      busy_d = (busy_q & ~clr) | cap;
      for (int c = 0; c < NC; c++) begin
         op_d[c] = cap[c] ? SEMAPHOREARBITER_Op[c] : op_q[c];
         id_d[c] = cap[c] ? SEMAPHOREARBITER_SemId[c*SemIdW +: SemIdW]
                          : id_q[c];
      end

      for (int c = 0; c < NC; c++) begin
         for (int s = 0; s < NS; s++) begin
            we_d[c*NS+s] = lock_d[s] && (owner_d[s] == CoreIdW'(c));
         end
      end
   end

   always_ff @(posedge SEMAPHOREARBITER_Clk or posedge SEMAPHOREARBITER_Reset) begin
      if (SEMAPHOREARBITER_Reset) begin
         state_q  <= ARB;
         busy_q   <= '0;
         op_q     <= '0;
         ack_q    <= '0;
         res_q    <= '0;
         win_oh_q <= '0;
         win_q    <= '0;
         ptr_q    <= '0;
         lock_q   <= '0;
         we_q     <= '0;
         for (int c = 0; c < NC; c++) id_q[c] <= '0;
         for (int s = 0; s < NS; s++) owner_q[s] <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         op_q     <= op_d;
         ack_q    <= ack_d;
         res_q    <= res_d;
         win_oh_q <= win_oh_d;
         win_q    <= win_d;
         ptr_q    <= ptr_d;
         lock_q   <= lock_d;
         we_q     <= we_d;
         for (int c = 0; c < NC; c++) id_q[c] <= id_d[c];
         for (int s = 0; s < NS; s++) owner_q[s] <= owner_d[s];
      end
   end

   assign SEMAPHOREARBITER_Ack       = ack_q;
   assign SEMAPHOREARBITER_Result    = res_q;
   assign SEMAPHOREARBITER_Busy      = busy_q;
   assign SEMAPHOREARBITER_Locked    = lock_q;
   assign SEMAPHOREARBITER_WE_buffer = we_q;

endmodule

// File: tb/tb_semaphore_arbiter.sv
// Directed bench for semaphore_arbiter: a 4-semaphore table and a
// 3-semaphore table sharing clock and reset.
module tb_semaphore_arbiter;

   logic       clk = 1'b0;
   logic       rst;

   logic [1:0] a_req, a_op, a_ack, a_res, a_busy;
   logic [3:0] a_id, a_lock;
   logic [7:0] a_we;

   logic [1:0] b_req, b_op, b_ack, b_res, b_busy;
   logic [3:0] b_id;
   logic [2:0] b_lock;
   logic [5:0] b_we;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   semaphore_arbiter #(
      .NumberOfSemaphores(4),
      .NumberOfCores(2)
   ) dut_a (
      .SEMAPHOREARBITER_Clk      (clk),
      .SEMAPHOREARBITER_Reset    (rst),
      .SEMAPHOREARBITER_Req      (a_req),
      .SEMAPHOREARBITER_Op       (a_op),
      .SEMAPHOREARBITER_SemId    (a_id),
      .SEMAPHOREARBITER_Ack      (a_ack),
      .SEMAPHOREARBITER_Result   (a_res),
      .SEMAPHOREARBITER_Busy     (a_busy),
      .SEMAPHOREARBITER_Locked   (a_lock),
      .SEMAPHOREARBITER_WE_buffer(a_we)
   );

   semaphore_arbiter #(
      .NumberOfSemaphores(3),
      .NumberOfCores(2)
   ) dut_b (
      .SEMAPHOREARBITER_Clk      (clk),
      .SEMAPHOREARBITER_Reset    (rst),
      .SEMAPHOREARBITER_Req      (b_req),
      .SEMAPHOREARBITER_Op       (b_op),
      .SEMAPHOREARBITER_SemId    (b_id),
      .SEMAPHOREARBITER_Ack      (b_ack),
      .SEMAPHOREARBITER_Result   (b_res),
      .SEMAPHOREARBITER_Busy     (b_busy),
      .SEMAPHOREARBITER_Locked   (b_lock),
      .SEMAPHOREARBITER_WE_buffer(b_we)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Single uncontended op on table A, issued at a falling edge.
   task automatic op_a(input int core, input logic op,
                       input logic [1:0] id, input logic exp_res);
      a_req                 = '0;
      a_req[core]           = 1'b1;
      a_op[core]            = op;
      a_id[core*2 +: 2]     = id;
      @(negedge clk);
      a_req = '0;
      chk("op_busy", 32'(a_busy), 32'(1 << core));
      chk("op_ack_c1", 32'(a_ack), 0);
      @(negedge clk);
      chk("op_ack_c2", 32'(a_ack), 0);
      @(negedge clk);
      chk("op_ack_c3", 32'(a_ack), 32'(1 << core));
      chk("op_result", 32'(a_res[core]), 32'(exp_res));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int acks;
      int expc;
      int last [2];
      int extra;

      rst   = 1'b1;
      a_req = '0; a_op = '0; a_id = '0;
      b_req = '0; b_op = '0; b_id = '0;
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(a_ack), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_lock", 32'(a_lock), 0);
      chk("rst_we", 32'(a_we), 0);
      chk("rst_res", 32'(a_res), 0);
      chk("rst_b_lock", 32'(b_lock), 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset lands while core0's acquire of sem2 is executing.
      a_req = 2'b01; a_op = 2'b01; a_id = 4'b0010;
      @(negedge clk);
      a_req = '0;
      chk("t1_busy", 32'(a_busy), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t1_ack", 32'(a_ack), 0);
      chk("t1_lock", 32'(a_lock), 0);
      chk("t1_we", 32'(a_we), 0);
      chk("t1_busy0", 32'(a_busy), 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_no_ack", 32'(a_ack), 0);
      end
      chk("t1_lock_after", 32'(a_lock), 0);

      // Basic acquire, try-lock refusal and releases.
      op_a(0, 1'b1, 2'd1, 1'b1);
      chk("t2_lock", 32'(a_lock), 32'h2);
      chk("t2_we", 32'(a_we), 32'h02);
      op_a(1, 1'b1, 2'd1, 1'b0);
      chk("t3_lock", 32'(a_lock), 32'h2);
      chk("t3_we", 32'(a_we), 32'h02);
      op_a(1, 1'b0, 2'd1, 1'b0);
      chk("t3_lock_b", 32'(a_lock), 32'h2);
      op_a(0, 1'b0, 2'd1, 1'b1);
      chk("t3_lock_c", 32'(a_lock), 0);
      chk("t3_we_c", 32'(a_we), 0);
      op_a(1, 1'b0, 2'd0, 1'b0);
      op_a(1, 1'b1, 2'd0, 1'b1);
      chk("t3_lock_d", 32'(a_lock), 32'h1);
      chk("t3_we_d", 32'(a_we), 32'h10);
      op_a(1, 1'b0, 2'd0, 1'b1);
      chk("t3_lock_e", 32'(a_lock), 0);

      // Simultaneous acquire of sem3 with the pointer back at core0.
      a_req = 2'b11; a_op = 2'b11; a_id = 4'b1111;
      @(negedge clk);
      a_req = '0;
      chk("t4_busy", 32'(a_busy), 32'h3);
      @(negedge clk);
      chk("t4_ack_n2", 32'(a_ack), 0);
      @(negedge clk);
      chk("t4_ack0", 32'(a_ack), 32'h1);
      chk("t4_res0", 32'(a_res[0]), 1);
      chk("t4_lock", 32'(a_lock), 32'h8);
      @(negedge clk);
      chk("t4_busy1", 32'(a_busy), 32'h2);
      chk("t4_ack_n4", 32'(a_ack), 0);
      @(negedge clk);
      chk("t4_ack_n5", 32'(a_ack), 0);
      @(negedge clk);
      chk("t4_ack1", 32'(a_ack), 32'h2);
      chk("t4_res", 32'(a_res), 32'h1);
      chk("t4_we", 32'(a_we), 32'h08);
      op_a(0, 1'b0, 2'd3, 1'b1);
      chk("t4_lock_end", 32'(a_lock), 0);

      // Both cores hold Req high: core0 on sem0, core1 on sem2.
      acks = 0;
      expc = 1;
      last[0] = -1;
      last[1] = -1;
      a_op = 2'b11; a_id = 4'b1000; a_req = 2'b11;
      for (int cyc = 0; cyc < 100 && acks < 20; cyc++) begin
         @(negedge clk);
         if (a_ack != 2'b00) begin
            chk("t5_order", 32'(a_ack), 32'(1 << expc));
            chk("t5_result", 32'(a_res[expc]), 1);
            if (last[expc] >= 0) chk("t5_gap", 32'(cyc - last[expc]), 6);
            last[expc] = cyc;
            expc ^= 1;
            acks++;
            if (acks == 20) a_req = '0;
         end
      end
      chk("t5_acks", 32'(acks), 20);
      for (int i = 0; i < 12 && a_busy != 2'b00; i++) @(negedge clk);
      chk("t5_drain", 32'(a_busy), 0);
      chk("t5_lock", 32'(a_lock), 32'h5);
      chk("t5_we", 32'(a_we), 32'h41);

      // Three-entry table: valid lock, out-of-range id, ignored re-Req.
      b_req = 2'b10; b_op = 2'b10; b_id = 4'b1000;
      @(negedge clk);
      b_req = '0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_ack1", 32'(b_ack), 32'h2);
      chk("t6_res1", 32'(b_res[1]), 1);
      chk("t6_lock1", 32'(b_lock), 32'h4);
      chk("t6_we1", 32'(b_we), 32'h20);
      b_req = 2'b01; b_op = 2'b01; b_id = 4'b0011;
      @(negedge clk);
      chk("t6_busy", 32'(b_busy), 32'h1);
      b_id = 4'b0000;
      @(negedge clk);
      b_req = '0;
      chk("t6_ack_n2", 32'(b_ack), 0);
      @(negedge clk);
      chk("t6_ack0", 32'(b_ack), 32'h1);
      chk("t6_res0", 32'(b_res[0]), 0);
      chk("t6_lock2", 32'(b_lock), 32'h4);
      chk("t6_we2", 32'(b_we), 32'h20);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b_ack != 2'b00) extra++;
      end
      chk("t6_extra_ack", 32'(extra), 0);
      chk("t6_busy_end", 32'(b_busy), 0);
      chk("t6_lock_end", 32'(b_lock), 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
